// File: rtl/sine_burst_sequencer_pkg.sv
// Shared types and constants for the sine burst sequencer: command record,
// sequencer state encoding and the command legality rule.
package sine_seq_pkg;

    localparam int PHASE_SIZE  = 8;
    localparam int COUNT_WIDTH = 16;
    localparam int TABLE_SIZE  = 64;
    localparam int MAX_STEP    = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        STREAM
    } seq_state_t;

    typedef struct packed {
        logic signed [PHASE_SIZE:0]  phase;
        logic signed [PHASE_SIZE:0]  step;
        logic        [COUNT_WIDTH-1:0] length;
    } sine_cmd_t;

    localparam logic signed [PHASE_SIZE:0] STEP_MIN = (PHASE_SIZE+1)'(1);
    localparam logic signed [PHASE_SIZE:0] STEP_MAX = (PHASE_SIZE+1)'(MAX_STEP);

    // A step outside 1..MAX_STEP would skip or reverse through the table.
    function automatic logic cmd_legal(input sine_cmd_t c);
        return (c.step >= STEP_MIN) && (c.step <= STEP_MAX) && (c.length != '0);
    endfunction

endpackage

// File: rtl/sine_burst_sequencer_if.sv
// Command handshake bundle between the register side and the sequencer.
interface sine_burst_sequencer_if;
    import sine_seq_pkg::*;

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic signed [PHASE_SIZE:0]    cmd_phase;
    logic signed [PHASE_SIZE:0]    cmd_step;
    logic        [COUNT_WIDTH-1:0] cmd_length;

    modport master (
        output cmd_valid,
        output cmd_phase,
        output cmd_step,
        output cmd_length,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_phase,
        input  cmd_step,
        input  cmd_length,
        output cmd_ready
    );

endinterface

// File: rtl/sine_burst_sequencer_cmd_fifo.sv
// Show-ahead command queue with flush; head entry is visible on dout while
// the queue is non-empty.
module sine_cmd_fifo
    import sine_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      flush,
    input  logic      push,
    input  sine_cmd_t din,
    input  logic      pop,
    output sine_cmd_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    sine_cmd_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] level;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sine_burst_sequencer.sv
// Sequences an owned sine_wave generator through queued finite bursts:
// load via a reset pulse, mask two settling cycles, then stream samples.
module sine_burst_sequencer #(
    parameter int PHASE_SIZE  = sine_seq_pkg::PHASE_SIZE,
    parameter int COUNT_WIDTH = sine_seq_pkg::COUNT_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    sine_burst_sequencer_if.slave       cmd,
    input  logic                        abort,
    output logic                        gen_reset,
    output logic signed [PHASE_SIZE:0]  gen_phase,
    output logic signed [PHASE_SIZE:0]  gen_phase_step,
    input  logic        [7:0]           sample_in,
    output logic        [7:0]           sample_out,
    output logic                        sample_valid,
    output logic                        sample_last,
    output logic                        busy,
    output logic                        cmd_error
);
    import sine_seq_pkg::*;

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    seq_state_t             state, state_next;
    logic                   settle, settle_next;
    logic [COUNT_WIDTH-1:0] remaining, remaining_next;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                   take_next, load, drop;
    sine_cmd_t              cmd_in, head;

    assign cmd_in.phase  = cmd.cmd_phase;
    assign cmd_in.step   = cmd.cmd_step;
    assign cmd_in.length = cmd.cmd_length;

    assign cmd.cmd_ready = !fifo_full;
    assign fifo_push     = cmd.cmd_valid && !fifo_full && !abort;
    assign busy          = (state != IDLE) || !fifo_empty;

    sine_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (abort),
        .push    (fifo_push),
        .din     (cmd_in),
        .pop     (fifo_pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_next     = state;
        settle_next    = settle;
        remaining_next = remaining;
        fifo_pop       = 1'b0;
        load           = 1'b0;
        drop           = 1'b0;
        take_next      = 1'b0;

        case (state)
            IDLE: take_next = !fifo_empty;
            LOAD: begin
                state_next  = SETTLE;
                settle_next = 1'b0;
            end
            SETTLE: begin
                if (settle) state_next  = STREAM;
                else        settle_next = 1'b1;
            end
            STREAM: begin
                remaining_next = remaining - ONE;
                if (remaining == ONE) begin
                    state_next = IDLE;
                    take_next  = !fifo_empty;
                end
            end
            default: state_next = IDLE;
        endcase

        // Popping straight from the last STREAM cycle avoids an IDLE bubble.
        if (take_next) begin
            fifo_pop = 1'b1;
            if (cmd_legal(head)) begin
                state_next     = LOAD;
                load           = 1'b1;
                remaining_next = head.length;
            end else begin
                drop = 1'b1;
            end
        end

        if (abort) begin
            state_next = IDLE;
            fifo_pop   = 1'b0;
            load       = 1'b0;
            drop       = 1'b0;
        end
    end

    // Samples are registered on every edge whose next state is STREAM, so the
    // first one is captured as SETTLE ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            settle         <= 1'b0;
            remaining      <= '0;
            gen_reset      <= 1'b1;
            gen_phase      <= '0;
            gen_phase_step <= (PHASE_SIZE+1)'(1);
            sample_out     <= '0;
            sample_valid   <= 1'b0;
            sample_last    <= 1'b0;
            cmd_error      <= 1'b0;
        end else begin
            state        <= state_next;
            settle       <= settle_next;
            remaining    <= remaining_next;
            gen_reset    <= load;
            cmd_error    <= drop;
            sample_valid <= (state_next == STREAM);
            sample_last  <= (state_next == STREAM) && (remaining_next == ONE);
            if (load) begin
                gen_phase      <= head.phase;
                gen_phase_step <= head.step;
            end
            if (state_next == STREAM) sample_out <= sample_in;
        end
    end

endmodule

// File: tb/tb_sine_burst_sequencer.sv
// Directed bench for sine_burst_sequencer with a scoreboard of expected bursts.
module tb_sine_burst_sequencer;
    import sine_seq_pkg::*;

    typedef struct {
        logic signed [8:0] phase;
        logic signed [8:0] step;
        int                length;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              abort;
    logic              gen_reset;
    logic signed [8:0] gen_phase;
    logic signed [8:0] gen_phase_step;
    logic [7:0]        sample_in;
    logic [7:0]        sample_out;
    logic              sample_valid;
    logic              sample_last;
    logic              busy;
    logic              cmd_error;

    sine_burst_sequencer_if cmd_bus ();

    sine_burst_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cmd            (cmd_bus),
        .abort          (abort),
        .gen_reset      (gen_reset),
        .gen_phase      (gen_phase),
        .gen_phase_step (gen_phase_step),
        .sample_in      (sample_in),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .sample_last    (sample_last),
        .busy           (busy),
        .cmd_error      (cmd_error)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic prev_gr = 1'b0;
    exp_t sb[$];
    int   burst_cnt = 0;
    int   total = 0;
    int   loads = 0;
    int   errs = 0;
    int   exp_errs = 0;
    int   last_acc = 0;
    int   first_cyc[$];
    int   last_cyc[$];
    logic [7:0] sample_drv = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (gen_reset) begin
            check("gen_reset_pulse", 32'(prev_gr), 32'(0));
            if (!prev_gr) begin
                loads++;
                if (sb.size() == 0) check("unexpected_load", 32'(gen_reset), 32'(0));
                else begin
                    check("gen_phase", 32'(gen_phase), 32'(sb[0].phase));
                    check("gen_phase_step", 32'(gen_phase_step), 32'(sb[0].step));
                end
            end
        end
        prev_gr = gen_reset;
        if (cmd_error) errs++;
        if (sample_valid) begin
            if (sb.size() == 0) check("unexpected_sample", 32'(sample_valid), 32'(0));
            else begin
                check("sample_out", 32'(sample_out), 32'(sample_drv));
                burst_cnt++;
                total++;
                if (burst_cnt == 1) first_cyc.push_back(cyc);
                check("sample_last", 32'(sample_last), 32'(burst_cnt == sb[0].length));
                if (burst_cnt == sb[0].length) begin
                    last_cyc.push_back(cyc);
                    void'(sb.pop_front());
                    burst_cnt = 0;
                end
            end
        end else if (sample_last) begin
            check("last_without_valid", 32'(sample_last), 32'(0));
        end
    endtask

    // Outputs are checked at the falling edge; sample_in changes there too.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (mon_en) monitor();
        sample_drv = 8'($urandom);
        sample_in  = sample_drv;
    endtask

    task automatic drive(input int ph, input int st, input int len);
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_phase  = 9'(ph);
        cmd_bus.cmd_step   = 9'(st);
        cmd_bus.cmd_length = 16'(len);
    endtask

    task automatic expect_cmd(input int ph, input int st, input int len);
        exp_t e;
        if (st >= 1 && st <= 32 && len != 0) begin
            e.phase  = 9'(ph);
            e.step   = 9'(st);
            e.length = len;
            sb.push_back(e);
        end else begin
            exp_errs++;
        end
    endtask

    task automatic send(input int ph, input int st, input int len);
        bit ok = 1'b0;
        drive(ph, st, len);
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_bus.cmd_ready) begin
                ok = 1'b1;
                expect_cmd(ph, st, len);
                last_acc = cyc + 1;
            end
            tick();
        end
        cmd_bus.cmd_valid = 1'b0;
        check("cmd_accept", 32'(ok), 32'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (busy || sb.size() != 0); i++) tick();
        tick();
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_sb_empty", 32'(sb.size()), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gen_reset"}, 32'(gen_reset), 32'(1));
        check({tag, "_gen_phase"}, 32'(gen_phase), 32'(0));
        check({tag, "_gen_step"}, 32'(gen_phase_step), 32'(1));
        check({tag, "_sample_out"}, 32'(sample_out), 32'(0));
        check({tag, "_valid"}, 32'(sample_valid), 32'(0));
        check({tag, "_last"}, 32'(sample_last), 32'(0));
        check({tag, "_cmd_error"}, 32'(cmd_error), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_ready"}, 32'(cmd_bus.cmd_ready), 32'(1));
    endtask

    initial begin
        int l0, t0, e0, fb, lb;
        reset_n = 1'b0;
        abort = 1'b0;
        sample_in = 8'h00;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_phase = '0;
        cmd_bus.cmd_step = '0;
        cmd_bus.cmd_length = '0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();
        check("gen_reset_release", 32'(gen_reset), 32'(0));
        prev_gr = 1'b0;
        mon_en = 1'b1;

        // Basic burst
        l0 = loads; t0 = total; fb = first_cyc.size();
        send(0, 1, 5);
        wait_idle();
        check("basic_loads", 32'(loads - l0), 32'(1));
        check("basic_samples", 32'(total - t0), 32'(5));
        check("basic_latency", 32'(first_cyc[fb] - last_acc), 32'(4));

        // Queue full and back-to-back
        l0 = loads; t0 = total; fb = first_cyc.size(); lb = last_cyc.size();
        send(10, 2, 3);
        for (int k = 0; k < 4; k++) send(k * 20, 3, 3);
        check("full_ready_low", 32'(cmd_bus.cmd_ready), 32'(0));
        wait_idle();
        check("b2b_loads", 32'(loads - l0), 32'(5));
        check("b2b_samples", 32'(total - t0), 32'(15));
        check("b2b_bursts", 32'(first_cyc.size() - fb), 32'(5));
        for (int k = 0; k < 4; k++)
            check("b2b_gap", 32'(first_cyc[fb + k + 1] - last_cyc[lb + k]), 32'(4));

        // Illegal commands
        l0 = loads; t0 = total; e0 = errs;
        send(0, 0, 4);
        send(0, 33, 4);
        send(0, 2, 0);
        wait_idle();
        check("illegal_errors", 32'(errs - e0), 32'(3));
        check("illegal_loads", 32'(loads - l0), 32'(0));
        check("illegal_samples", 32'(total - t0), 32'(0));

        // Abort in the second STREAM cycle with two entries queued
        send(10, 1, 10);
        send(30, 1, 4);
        send(40, 1, 4);
        for (int i = 0; i < 30 && !sample_valid; i++) tick();
        check("abort_streaming", 32'(sample_valid), 32'(1));
        tick();
        abort = 1'b1;
        drive(50, 3, 2);
        sb.delete();
        burst_cnt = 0;
        tick();
        abort = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        check("abort_valid", 32'(sample_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_ready", 32'(cmd_bus.cmd_ready), 32'(1));
        l0 = loads; t0 = total;
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_load", 32'(loads - l0), 32'(0));
        check("abort_no_samples", 32'(total - t0), 32'(0));

        // Asynchronous reset mid-burst
        send(20, 2, 8);
        for (int i = 0; i < 30 && !sample_valid; i++) tick();
        tick();
        tick();
        check("rst_streaming", 32'(sample_valid), 32'(1));
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        mon_en = 1'b0;
        sb.delete();
        burst_cnt = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("midrst_release", 32'(gen_reset), 32'(0));
        prev_gr = 1'b0;
        mon_en = 1'b1;
        l0 = loads; t0 = total;
        send(-90, 4, 3);
        wait_idle();
        check("postrst_loads", 32'(loads - l0), 32'(1));
        check("postrst_samples", 32'(total - t0), 32'(3));

        // Push and pop in the same cycle at the end of a burst
        l0 = loads; t0 = total; fb = first_cyc.size(); lb = last_cyc.size();
        send(0, 1, 3);
        send(60, 5, 3);
        for (int i = 0; i < 30 && !sample_last; i++) tick();
        check("pp_last_seen", 32'(sample_last), 32'(1));
        drive(70, 6, 3);
        check("pp_ready", 32'(cmd_bus.cmd_ready), 32'(1));
        expect_cmd(70, 6, 3);
        tick();
        cmd_bus.cmd_valid = 1'b0;
        check("pp_busy", 32'(busy), 32'(1));
        send(80, 7, 3);
        send(90, 8, 3);
        send(100, 9, 3);
        check("pp_full_after_three", 32'(cmd_bus.cmd_ready), 32'(0));
        wait_idle();
        check("pp_gap", 32'(first_cyc[fb + 1] - last_cyc[lb]), 32'(4));
        check("pp_loads", 32'(loads - l0), 32'(6));
        check("pp_samples", 32'(total - t0), 32'(18));
        check("error_total", 32'(errs), 32'(exp_errs));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
